div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: CPU_WIDTH, 32, operand and result width.
REQ-002 Parameter: DIV_CNT_WIDTH, 6, iteration counter width (must hold CPU_WIDTH).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: div_start_i  input  1  level request; sampled only in IDLE.
REQ-006 Port: div_op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 Port: dividend_i  input  CPU_WIDTH  dividend (rs1).
REQ-008 Port: divisor_i  input  CPU_WIDTH  divisor (rs2).
REQ-009 Port: flush_i  input  1  pipeline flush; aborts any operation in flight.
REQ-010 Port: div_result_o  output  CPU_WIDTH  registered quotient or remainder.
REQ-011 Port: div_res_ready_o  output  1  one-cycle result-valid pulse.
REQ-012 Port: div_busy_o  output  1  high while in CALC.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 IDLE SHALL move to CALC on an edge where div_start_i=1 and flush_i=0, latching op, dividend and divisor.
REQ-015 Operand and op input changes after acceptance SHALL be ignored until the next acceptance.
REQ-016 div_start_i SHALL be ignored in CALC and DONE.
REQ-017 Signed ops (DIV, REM): SHALL divide |dividend| by |divisor| unsigned; quotient negated when operand signs differ; remainder takes dividend sign.
REQ-018 Unsigned ops (DIVU, REMU): SHALL use raw operands.
REQ-019 CALC SHALL run one restoring radix-2 iteration per cycle, MSB first: shift remainder left, bring in next dividend bit, subtract divisor if no borrow, set quotient bit.
REQ-020 CALC SHALL use a counter starting at 0 on acceptance and SHALL move to DONE on the edge completing iteration CPU_WIDTH-1 (32 iterations).
REQ-021 Sign correction and quotient/remainder selection SHALL be registered into div_result_o on the CALC->DONE edge.
REQ-022 Divisor zero SHALL skip CALC (IDLE->DONE directly): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
REQ-023 DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF SHALL skip CALC: DIV result 0x80000000, REM result 0.
REQ-024 Latency: normal ops SHALL assert div_res_ready_o in the 33rd cycle after the acceptance edge; special cases in the cycle after acceptance.
REQ-025 div_res_ready_o SHALL be high only in DONE; DONE SHALL last exactly one cycle, then go to IDLE.
REQ-026 div_result_o SHALL hold its value after DONE until the next DONE.
REQ-027 div_busy_o SHALL be 1 in CALC only.
REQ-028 Back-to-back: a start asserted in the first IDLE cycle after DONE SHALL be accepted normally.
REQ-029 flush_i=1 SHALL force IDLE on that edge from any state, with no ready pulse; div_result_o SHALL remain unchanged.
REQ-030 flush_i and div_start_i both high in IDLE: flush SHALL win; no acceptance.

Reset
REQ-031 rst=1 SHALL, on the clock edge, force IDLE, clear the counter and internal registers, and set div_result_o=0, div_res_ready_o=0, div_busy_o=0.
REQ-032 rst SHALL take priority over flush_i and div_start_i; reset mid-CALC SHALL discard the operation with no ready pulse.

Verification
REQ-033 DIVU 100/7: start 1 cycle -> busy 32 cycles; ready in 33rd cycle, result 14; REMU -> 2.
REQ-034 DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-035 DIVU 5/0 -> ready next cycle, 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> ready next cycle, 0; DIV same operands -> 0x80000000.
REQ-036 Start DIVU 100/7, flush_i at CALC cycle 10 -> IDLE, no ready pulse, div_result_o unchanged; next start completes correctly.
REQ-037 rst at CALC cycle 20 -> all outputs 0 next cycle; start held high throughout -> new op accepted on the first IDLE edge with rst=0.
REQ-038 Back-to-back DIVU 9/3 then REMU 9/4 with start re-asserted right after ready -> results 3 then 1, each with exactly one ready pulse.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between a pipeline and the divider
interface div_unit_if #(parameter int CPU_WIDTH = 32);
  logic                 div_start_i;
  logic [1:0]           div_op_i;
  logic [CPU_WIDTH-1:0] dividend_i;
  logic [CPU_WIDTH-1:0] divisor_i;
  logic                 flush_i;
  logic [CPU_WIDTH-1:0] div_result_o;
  logic                 div_res_ready_o;
  logic                 div_busy_o;
  modport master (
    output div_start_i, div_op_i, dividend_i, divisor_i, flush_i,
    input  div_result_o, div_res_ready_o, div_busy_o
  );
  modport slave (
    input  div_start_i, div_op_i, dividend_i, divisor_i, flush_i,
    output div_result_o, div_res_ready_o, div_busy_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU
module div_unit #(
  parameter int CPU_WIDTH     = 32,
  parameter int DIV_CNT_WIDTH = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [CPU_WIDTH-1:0] MIN = {1'b1, {(CPU_WIDTH-1){1'b0}}};
  state_t                 state, state_n;
  logic [DIV_CNT_WIDTH-1:0] cnt;
  logic                   rem_sel, dvd_neg, dvs_neg;
  logic [CPU_WIDTH-1:0]   rem, quo, dvs, result;
  logic                   accept, special, last, is_signed, no_borrow;
  logic [CPU_WIDTH:0]     rem_shift;
  logic [CPU_WIDTH-1:0]   rem_n, quo_n, fin, spec_res;
  always_comb begin
    accept    = state == IDLE && bus.div_start_i && !bus.flush_i;
    is_signed = !bus.div_op_i[0];
    special   = bus.divisor_i == '0 || (is_signed && bus.dividend_i == MIN && bus.divisor_i == '1);
    spec_res  = bus.divisor_i == '0 ? (bus.div_op_i[1] ? bus.dividend_i : '1) : (bus.div_op_i[1] ? '0 : MIN);
    last      = cnt == DIV_CNT_WIDTH'(CPU_WIDTH - 1);
    rem_shift = {rem, quo[CPU_WIDTH-1]};
    no_borrow = rem_shift >= {1'b0, dvs};
    rem_n     = no_borrow ? CPU_WIDTH'(rem_shift - {1'b0, dvs}) : rem_shift[CPU_WIDTH-1:0];
    quo_n     = {quo[CPU_WIDTH-2:0], no_borrow};
    fin       = rem_sel ? (dvd_neg ? -rem_n : rem_n) : (dvd_neg ^ dvs_neg ? -quo_n : quo_n);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = bus.flush_i ? IDLE :
              state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE) :
              state == CALC ? (last ? DONE : CALC) : IDLE;
  always_comb begin
    bus.div_busy_o      = state == CALC;
    bus.div_res_ready_o = state == DONE;
    bus.div_result_o    = result;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt     <= '0;
      rem_sel <= 1'b0;
      dvd_neg <= 1'b0;
      dvs_neg <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      result  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      rem_sel <= bus.div_op_i[1];
      dvd_neg <= is_signed && bus.dividend_i[CPU_WIDTH-1];
      dvs_neg <= is_signed && bus.divisor_i[CPU_WIDTH-1];
      rem     <= '0;
      quo     <= is_signed && bus.dividend_i[CPU_WIDTH-1] ? -bus.dividend_i : bus.dividend_i;
      dvs     <= is_signed && bus.divisor_i[CPU_WIDTH-1] ? -bus.divisor_i : bus.divisor_i;
      if (special) result <= spec_res;
    end else if (state == CALC && !bus.flush_i) begin
      cnt <= cnt + DIV_CNT_WIDTH'(1);
      rem <= rem_n;
      quo <= quo_n;
      if (last) result <= fin;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit against an arithmetic reference model
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div_unit_if #(.CPU_WIDTH(32)) bus ();
  div_unit #(.CPU_WIDTH(32), .DIV_CNT_WIDTH(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        sp;
  } vec_t;
  vec_t dir [12] = '{
    '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0},
    '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0},
    '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0},
    '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0},
    '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0},
    '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1},
    '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1},
    '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1},
    '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1},
    '{2'b00, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1'b1},
    '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0},
    '{2'b11, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0}
  };
  logic [31:0] exp_q [$];
  logic [31:0] last_res = '0;
  int n_tests = 0;
  int n_fail  = 0;
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : 32'h80000000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction
  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.div_res_ready_o) begin
      if (exp_q.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
      else chk("result", bus.div_result_o, exp_q.pop_front());
    end
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    @(negedge clk);
    bus.div_op_i    = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.div_start_i = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      last_res = exp;
    end
    @(posedge clk);
  endtask
  task automatic wait_done(input bit sp, input string nm);
    int lat = 0;
    int busy = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        bus.div_start_i = 1'b0;
        bus.dividend_i  = $urandom;
        bus.divisor_i   = $urandom;
        bus.div_op_i    = 2'($urandom);
      end
      lat++;
      busy += int'(bus.div_busy_o);
    end while (!bus.div_res_ready_o && lat < 40);
    chk({nm, "_latency"}, lat, sp ? 32'd1 : 32'd33);
    chk({nm, "_busy_cycles"}, busy, sp ? 32'd0 : 32'd32);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    bus.div_start_i = 1'b0;
    bus.div_op_i    = 2'b00;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.flush_i     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", bus.div_result_o, 32'd0);
    chk("reset_ready", 32'(bus.div_res_ready_o), 32'd0);
    chk("reset_busy", 32'(bus.div_busy_o), 32'd0);
    rst = 1'b0;
    foreach (dir[i]) begin
      issue(dir[i].op, dir[i].a, dir[i].b, dir[i].r, 1'b1);
      wait_done(dir[i].sp, "directed");
    end
    issue(2'b01, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      bus.div_start_i = 1'b0;
    end
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_busy", 32'(bus.div_busy_o), 32'd0);
    chk("flush_ready", 32'(bus.div_res_ready_o), 32'd0);
    chk("flush_result_held", bus.div_result_o, last_res);
    repeat (40) @(negedge clk);
    chk("flush_result_still_held", bus.div_result_o, last_res);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_done(1'b0, "after_flush");
    @(negedge clk);
    bus.div_op_i    = 2'b01;
    bus.dividend_i  = 32'd100;
    bus.divisor_i   = 32'd7;
    bus.div_start_i = 1'b1;
    bus.flush_i     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.div_start_i = 1'b0;
    bus.flush_i     = 1'b0;
    chk("flush_wins_busy", 32'(bus.div_busy_o), 32'd0);
    chk("flush_wins_ready", 32'(bus.div_res_ready_o), 32'd0);
    issue(2'b01, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midcalc_reset_result", bus.div_result_o, 32'd0);
    chk("midcalc_reset_ready", 32'(bus.div_res_ready_o), 32'd0);
    chk("midcalc_reset_busy", 32'(bus.div_busy_o), 32'd0);
    exp_q.push_back(32'd14);
    last_res = 32'd14;
    rst = 1'b0;
    @(posedge clk);
    wait_done(1'b0, "after_reset");
    issue(2'b01, 32'd9, 32'd3, 32'd3, 1'b1);
    wait_done(1'b0, "b2b_first");
    bus.div_op_i    = 2'b11;
    bus.dividend_i  = 32'd9;
    bus.divisor_i   = 32'd4;
    bus.div_start_i = 1'b1;
    exp_q.push_back(32'd1);
    @(posedge clk);
    @(posedge clk);
    wait_done(1'b0, "b2b_second");
    repeat (150) begin
      op = 2'($urandom);
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2, 3: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(op, a, b, model(op, a, b), 1'b1);
      wait_done(is_special(op, a, b), "random");
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
